delay_line: RTL
===============

# delay_line

Parametrised, enable-gated multi-stage register pipeline with a per-stage valid bit, a selectable output tap, a synchronous clear and a fill indicator. It generalises the single D flip-flop with asynchronous active-low reset into a WIDTH-bit, DEPTH-stage delay element. Datapath blocks use it to align signals by a programmable number of clock cycles.

## Interface
Parameters:
- WIDTH, 8: data bits per stage; legal range ≥1.
- DEPTH, 4: number of stages; legal range ≥1.
- TAPW, max(1, $clog2(DEPTH)): width of tap_sel. Derived; do not override.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- n_res  input  1  reset; asynchronous assertion, active-low; clears all state.
- en  input  1  shift enable; stages advance only when en=1.
- clr  input  1  synchronous clear; has priority over en.
- D  input  WIDTH  data into stage 0.
- in_valid  input  1  valid flag accompanying D.
- tap_sel  input  TAPW  output stage select; delay = tap_sel+1 enabled cycles.
- Q  output  WIDTH  data of the selected stage.
- out_valid  output  1  valid bit of the selected stage.
- primed  output  1  high once DEPTH enabled shifts have occurred since the last reset or clear.

## Operation
- State:
  - stage registers s[0..DEPTH-1], each WIDTH bits.
  - valid bits v[0..DEPTH-1].
  - fill counter fcnt, range 0..DEPTH, TAPW+1 bits.
- Rising-edge priority, highest first: n_res=0, then clr=1, then en=1, then hold.
- Clear (clr=1): all s, v and fcnt set to 0 on the next edge. en is ignored in that cycle.
- Shift (en=1, clr=0):
  - s[0]<=D and v[0]<=in_valid.
  - s[i]<=s[i-1] and v[i]<=v[i-1] for i=1..DEPTH-1.
  - fcnt<=fcnt+1, saturating at DEPTH.
- Hold (en=0, clr=0): all state unchanged, including fcnt. D and in_valid are ignored.
- Output select:
  - Q=s[k] and out_valid=v[k], where k=tap_sel.
  - If tap_sel ≥ DEPTH, k=DEPTH-1 (clamp; never X).
  - The output mux is combinational from registered state. No extra register.
- primed = (fcnt==DEPTH), driven directly from the register.
- Data of an invalid stage is still shifted and still presented on Q. out_valid qualifies it.
- DEPTH=1: tap_sel is 1 bit and every value selects s[0]. primed rises after the first enabled shift.

## Timing
- Reset value of every output: Q=0, out_valid=0, primed=0.
  - Asserting n_res clears outputs asynchronously, with no clock edge required.
  - Outputs read 0 within the same simulation timestep plus delta cycles.
- While n_res=0, state holds at 0 through any number of clock edges, regardless of D, en, clr or in_valid.
- Reset release: the first rising edge with n_res=1 performs a normal update.
- Latency: a word presented with en=1 at edge N appears on Q at edge N+tap_sel, given en=1 on every intervening edge.
  - tap_sel=0 means Q reflects D one edge later.
  - Cycles with en=0 stretch latency one-for-one.
- tap_sel change: Q and out_valid update combinationally in the same cycle. No pipeline flush occurs.
- Simultaneous clr=1 and en=1: clear wins; D is dropped.
- Reset asserted mid-operation: all in-flight data is lost and primed drops immediately.
- fcnt saturation: fcnt never wraps. primed stays high until the next reset or clear.

## Test plan
WIDTH=8, DEPTH=4 for all scenarios.
1. Reset: drive n_res=0 with s holding 8'hA5 and v=1. Q=0, out_valid=0 and primed=0 are required 10 ps after the falling edge of n_res, with no clock edge. Hold n_res=0 for 3 edges with en=1 and D=8'hFF; Q must stay 0.
2. Latency sweep: tap_sel=2, en=1, in_valid=1, D=8'h11,8'h22,8'h33,8'h44 on consecutive falling edges.
   - Q=8'h11 with out_valid=1 after the 3rd rising edge following the first write.
   - primed=1 after the 4th enabled edge.
3. Enable stall: same stream with en=0 for 2 cycles between 8'h22 and 8'h33. Q holds its value during the stall and 8'h11 arrives 2 cycles late. fcnt and primed do not advance during the stall.
4. Tap clamp: fill with 8'h01..8'h04. tap_sel=3 gives Q=8'h01. With TAPW=2 every value is in range, so additionally run DEPTH=3 with tap_sel=3: Q must equal s[2] and never be X.
5. Clear priority: after primed=1, assert clr=1 and en=1 with D=8'hEE. Next edge: Q=0, out_valid=0, primed=0. 8'hEE must not appear at any tap.
6. Valid tracking: in_valid pattern 1,0,1,1 with tap_sel=3. The out_valid sequence at stage 3 is 1,0,1,1 with the matching data, starting on the 4th enabled edge.

Source files
------------

// File: rtl/delay_line.sv
// Enable-gated WIDTH x DEPTH register pipeline with per-stage valid bits,
// a clamped combinational output tap, synchronous clear and a fill indicator.
`timescale 1ns/1ps
module delay_line #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAPW  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             CLK,
    input  logic             n_res,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] D,
    input  logic             in_valid,
    input  logic [TAPW-1:0]  tap_sel,
    output logic [WIDTH-1:0] Q,
    output logic             out_valid,
    output logic             primed
);

    localparam logic [TAPW:0] FillMax = (TAPW + 1)'(DEPTH);
    localparam logic [TAPW:0] LastIdx = (TAPW + 1)'(DEPTH - 1);

    logic [WIDTH-1:0] r_stage [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [TAPW:0]    r_fcnt;

    logic [TAPW:0]    w_sel;
    logic [WIDTH-1:0] w_q;
    logic             w_v;

    always_ff @(posedge CLK or negedge n_res) begin
        if (!n_res) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
            r_valid <= '0;
            r_fcnt  <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
            r_valid <= '0;
            r_fcnt  <= '0;
        end else if (en) begin
            r_stage[0] <= D;
            r_valid[0] <= in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
                r_valid[i] <= r_valid[i-1];
            end
            // Saturate so primed never drops until reset or clear.
            if (r_fcnt != FillMax) begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end
    end

    // Out-of-range taps clamp to the last stage so Q is never X.
    always_comb begin
        w_sel = {1'b0, tap_sel};
        if (w_sel > LastIdx) begin
            w_sel = LastIdx;
        end
    end

    always_comb begin
        w_q = '0;
        w_v = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_sel == (TAPW + 1)'(i)) begin
                w_q = r_stage[i];
                w_v = r_valid[i];
            end
        end
    end

    assign Q         = w_q;
    assign out_valid = w_v;
    assign primed    = (r_fcnt == FillMax);

endmodule
